// File: rtl/vrf_pkg.sv
// Shared types and default geometry for the vector register file.
// Optional same-cycle write-to-read forwarding is enabled with VRF_BYPASS_EN.
package vrf_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } vrf_state_t;

    localparam int VRF_LANES  = 8;
    localparam int VRF_LANE_W = 8;
    localparam int VRF_NREGS  = 16;
    localparam int VRF_NRD    = 2;

endpackage

// File: rtl/vrf_lane_merge.sv
// Lane-masked merge: lanes with mask=1 take new_data, the rest keep old_data.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module vrf_lane_merge #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8
) (
    input  logic [LANES*LANE_W-1:0] old_data,
    input  logic [LANES*LANE_W-1:0] new_data,
    input  logic [LANES-1:0]        mask,
    output logic [LANES*LANE_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: NRD async read ports, one lane-masked write port, hardware clear sweep.
// Latency: reads combinational, writes visible next cycle (same cycle with VRF_BYPASS_EN).
// Backpressure: wr_ready low while sweeping or when clr_req is asserted; producer holds the write.
module vector_register_file
    import vrf_pkg::*;
#(
    parameter int LANES  = VRF_LANES,
    parameter int LANE_W = VRF_LANE_W,
    parameter int NREGS  = VRF_NREGS,
    parameter int NRD    = VRF_NRD
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr_req,
    output logic                                busy,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [$clog2(NREGS)-1:0]            wr_addr,
    input  logic [LANES-1:0]                    wr_mask,
    input  logic [LANES*LANE_W-1:0]             wr_data,
    input  logic [NRD*$clog2(NREGS)-1:0]        rd_addr,
    output logic [NRD*LANES*LANE_W-1:0]         rd_data
);

    localparam int              AW       = $clog2(NREGS);
    localparam int              VW       = LANES * LANE_W;
    localparam logic [AW:0]     NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW-1:0]   LAST_PTR = AW'(NREGS - 1);

    vrf_state_t     state;
    logic [AW-1:0]  ptr;
    logic [VW-1:0]  regs [NREGS];

    logic           wr_fire;
    logic           wr_in_range;
    logic [VW-1:0]  wr_old;
    logic [VW-1:0]  wr_merged;

    // busy is kept as its own flop so the read gating never sees a decoded glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    if (ptr == LAST_PTR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    assign wr_ready    = (state == IDLE) & ~clr_req;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < NREGS_W;
    assign wr_old      = wr_in_range ? regs[wr_addr] : '0;

    vrf_lane_merge #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_wr_merge (
        .old_data (wr_old),
        .new_data (wr_data),
        .mask     (wr_mask),
        .merged   (wr_merged)
    );

    // Storage has no reset: the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            regs[ptr] <= '0;
        end else if (wr_fire && wr_in_range) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok;
        logic [VW-1:0] stored;
        logic [VW-1:0] port_val;

        assign ra     = rd_addr[p*AW +: AW];
        assign ra_ok  = {1'b0, ra} < NREGS_W;
        assign stored = ra_ok ? regs[ra] : '0;

`ifdef VRF_BYPASS_EN
        logic [LANES-1:0] byp_mask;

        assign byp_mask = (wr_fire && (ra == wr_addr)) ? wr_mask : '0;

        vrf_lane_merge #(
            .LANES  (LANES),
            .LANE_W (LANE_W)
        ) u_byp_merge (
            .old_data (stored),
            .new_data (wr_data),
            .mask     (byp_mask),
            .merged   (port_val)
        );
`else
        assign port_val = stored;
`endif

        // Out-of-range addresses stay zero even if a dropped write targets them.
        assign rd_data[p*VW +: VW] = (busy || !ra_ok) ? '0 : port_val;
    end

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file (default geometry plus a 12x(4x16), 3-read-port instance).
// Expectations come from a register-array model updated with masked-lane arithmetic.
module tb_vector_register_file;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr_req;
    logic         busy;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_mask;
    logic [63:0]  wr_data;
    logic [7:0]   rd_addr;
    logic [127:0] rd_data;

    logic         s_clr_req;
    logic         s_busy;
    logic         s_wr_valid;
    logic         s_wr_ready;
    logic [3:0]   s_wr_addr;
    logic [3:0]   s_wr_mask;
    logic [63:0]  s_wr_data;
    logic [11:0]  s_rd_addr;
    logic [191:0] s_rd_data;

    int errors = 0;
    int checks = 0;

    logic [63:0] model   [16];
    logic [63:0] s_model [12];

    vector_register_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    vector_register_file #(
        .LANES  (4),
        .LANE_W (16),
        .NREGS  (12),
        .NRD    (3)
    ) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (s_clr_req),
        .busy     (s_busy),
        .wr_valid (s_wr_valid),
        .wr_ready (s_wr_ready),
        .wr_addr  (s_wr_addr),
        .wr_mask  (s_wr_mask),
        .wr_data  (s_wr_data),
        .rd_addr  (s_rd_addr),
        .rd_data  (s_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Lane i of the result is new_v's lane when mask[i] is set, otherwise old_v's lane.
    function automatic logic [63:0] merge_ref(input logic [63:0] old_v, input logic [63:0] new_v,
                                              input logic [7:0] mask, input int lanes, input int lw);
        logic [63:0] bm;
        bm = '0;
        for (int i = 0; i < lanes; i++) begin
            if (mask[i]) bm = bm | (((64'd1 << lw) - 64'd1) << (i * lw));
        end
        return (old_v & ~bm) | (new_v & bm);
    endfunction

    task automatic drive_write(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m,
                               output logic fired);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        @(negedge clk);
        fired = wr_ready;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        if (fired) model[a] = merge_ref(model[a], d, m, 8, 8);
    endtask

    task automatic s_drive_write(input logic [3:0] a, input logic [63:0] d, input logic [3:0] m,
                                 output logic fired);
        s_wr_valid = 1'b1;
        s_wr_addr  = a;
        s_wr_data  = d;
        s_wr_mask  = m;
        @(negedge clk);
        fired = s_wr_ready;
        @(posedge clk); #1;
        s_wr_valid = 1'b0;
        if (fired && a < 4'd12) s_model[a] = merge_ref(s_model[a], d, {4'b0, m}, 4, 16);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_addr = 8'h53;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || rd_data !== 128'h0)
            $display("FAIL reset_state: busy=%b wr_ready=%b rd_data=%h, want 1 0 0", busy, wr_ready, rd_data);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || wr_ready !== 1'b0 || rd_data !== 128'h0) begin
                errors++;
                $display("FAIL reset_sweep cyc%0d: busy=%b wr_ready=%b rd_data=%h, want 1 0 0",
                         c, busy, wr_ready, rd_data);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_done: busy=%b wr_ready=%b, want 0 1", busy, wr_ready);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 16; r++) model[r] = 64'h0;
        for (int r = 0; r < 12; r++) s_model[r] = 64'h0;
        for (int r = 0; r < 16; r += 2) begin
            rd_addr = {4'(r + 1), 4'(r)};
            #1;
            checks++;
            if (rd_data !== 128'h0) begin
                errors++;
                $display("FAIL reset_zero r%0d: got %h want 0", r, rd_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_masked_write();
        logic fired;
        drive_write(4'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, fired);
        checks++;
        if (fired !== 1'b1) begin
            errors++;
            $display("FAIL masked_write_ready1: wr_ready=%b want 1", fired);
        end
        drive_write(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, fired);
        checks++;
        if (fired !== 1'b1) begin
            errors++;
            $display("FAIL masked_write_ready2: wr_ready=%b want 1", fired);
        end
        rd_addr = {4'd3, 4'd3};
        #1;
        checks++;
        if (rd_data[63:0] !== 64'h0123_4567_FFFF_FFFF) begin
            errors++;
            $display("FAIL masked_write_p0: got %h want 0123_4567_ffff_ffff", rd_data[63:0]);
        end
        checks++;
        if (rd_data[127:64] !== 64'h0123_4567_FFFF_FFFF) begin
            errors++;
            $display("FAIL masked_write_p1: got %h want 0123_4567_ffff_ffff", rd_data[127:64]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        logic        fired;
        logic [63:0] old_v;
        logic [63:0] new_v;
        logic [63:0] exp_v;
        old_v = {$urandom, $urandom};
        new_v = ~old_v;
        drive_write(4'd5, old_v, 8'hFF, fired);
        wr_valid = 1'b1;
        wr_addr  = 4'd5;
        wr_data  = new_v;
        wr_mask  = 8'h5A;
        rd_addr  = {4'd5, 4'd5};
        @(negedge clk);
`ifdef VRF_BYPASS_EN
        exp_v = merge_ref(old_v, new_v, 8'h5A, 8, 8);
`else
        exp_v = old_v;
`endif
        checks++;
        if (rd_data[63:0] !== exp_v) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h want %h", rd_data[63:0], exp_v);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        model[5] = merge_ref(old_v, new_v, 8'h5A, 8, 8);
        #1;
        checks++;
        if (rd_data[127:64] !== model[5]) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h want %h", rd_data[127:64], model[5]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_traffic();
        logic        v;
        logic [3:0]  a;
        logic [63:0] d;
        logic [7:0]  m;
        logic [3:0]  ra [2];
        logic [63:0] exp_v;
        for (int it = 0; it < 300; it++) begin
            v     = ($urandom_range(0, 3) != 0);
            a     = 4'($urandom_range(0, 15));
            d     = {$urandom, $urandom};
            m     = 8'($urandom);
            ra[0] = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
            ra[1] = 4'($urandom_range(0, 15));
            wr_valid = v;
            wr_addr  = a;
            wr_data  = d;
            wr_mask  = m;
            rd_addr  = {ra[1], ra[0]};
            @(negedge clk);
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_ready it%0d: got %b want 1", it, wr_ready);
            end
            for (int p = 0; p < 2; p++) begin
                exp_v = model[ra[p]];
`ifdef VRF_BYPASS_EN
                if (v && ra[p] == a) exp_v = merge_ref(model[ra[p]], d, m, 8, 8);
`endif
                checks++;
                if (rd_data[p*64 +: 64] !== exp_v) begin
                    errors++;
                    $display("FAIL rand_read it%0d p%0d addr%0d: got %h want %h",
                             it, p, ra[p], rd_data[p*64 +: 64], exp_v);
                end
            end
            @(posedge clk); #1;
            if (v) model[a] = merge_ref(model[a], d, m, 8, 8);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_clr_vs_write();
        logic fired;
        drive_write(4'd7, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, fired);
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 4'd9;
        wr_data  = 64'h1111_2222_3333_4444;
        wr_mask  = 8'hFF;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_write_ready: wr_ready=%b busy=%b, want 0 0", wr_ready, busy);
        end
        @(posedge clk); #1;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || rd_data !== 128'h0) begin
                errors++;
                $display("FAIL clr_sweep cyc%0d: busy=%b rd_data=%h, want 1 0", c, busy, rd_data);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_done: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 16; r++) model[r] = 64'h0;
        for (int r = 0; r < 16; r += 2) begin
            rd_addr = {4'(r + 1), 4'(r)};
            #1;
            checks++;
            if (rd_data !== 128'h0) begin
                errors++;
                $display("FAIL clr_zero r%0d: got %h want 0", r, rd_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clr_ignored_and_reset();
        logic fired;
        drive_write(4'd2, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, fired);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 4) clr_req = 1'b1;
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL clr_ignored cyc%0d: busy=%b want 1", c, busy);
            end
            @(posedge clk); #1;
            clr_req = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_ignored_done: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 16; r++) model[r] = 64'h0;

        drive_write(4'd4, 64'h7777_8888_9999_AAAA, 8'hFF, fired);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 4'd4;
        wr_data  = 64'h1234_1234_1234_1234;
        wr_mask  = 8'hFF;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || rd_data !== 128'h0) begin
            errors++;
            $display("FAIL midsweep_reset: busy=%b wr_ready=%b rd_data=%h, want 1 0 0",
                     busy, wr_ready, rd_data);
        end
        @(posedge clk); #1;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_sweep cyc%0d: busy=%b want 1", c, busy);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 16; r++) model[r] = 64'h0;
        for (int r = 0; r < 12; r++) s_model[r] = 64'h0;
        for (int r = 0; r < 16; r += 2) begin
            rd_addr = {4'(r + 1), 4'(r)};
            #1;
            checks++;
            if (rd_data !== 128'h0) begin
                errors++;
                $display("FAIL restart_zero r%0d: got %h want 0", r, rd_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_small_config();
        logic fired;
        int   guard;
        guard = 0;
        while (s_busy !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL small_idle: busy=%b want 0", s_busy);
        end
        for (int r = 0; r < 12; r++) begin
            s_drive_write(4'(r), {$urandom, $urandom}, 4'hF, fired);
        end
        s_rd_addr  = {4'd13, 4'd5, 4'd13};
        s_wr_valid = 1'b1;
        s_wr_addr  = 4'd13;
        s_wr_data  = 64'hFEED_FACE_0BAD_C0DE;
        s_wr_mask  = 4'hF;
        @(negedge clk);
        checks++;
        if (s_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL small_oor_fire: wr_ready=%b want 1", s_wr_ready);
        end
        checks++;
        if (s_rd_data[63:0] !== 64'h0 || s_rd_data[191:128] !== 64'h0) begin
            errors++;
            $display("FAIL small_oor_read_during_write: p0=%h p2=%h want 0 0",
                     s_rd_data[63:0], s_rd_data[191:128]);
        end
        @(posedge clk); #1;
        s_wr_valid = 1'b0;
        for (int r = 0; r < 12; r += 3) begin
            s_rd_addr = {4'(r + 2), 4'(r + 1), 4'(r)};
            #1;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (s_rd_data[p*64 +: 64] !== s_model[r + p]) begin
                    errors++;
                    $display("FAIL small_read r%0d: got %h want %h", r + p,
                             s_rd_data[p*64 +: 64], s_model[r + p]);
                end
            end
        end
        s_rd_addr = {4'd15, 4'd14, 4'd13};
        #1;
        checks++;
        if (s_rd_data !== 192'h0) begin
            errors++;
            $display("FAIL small_oor_read: got %h want 0", s_rd_data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        clr_req    = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_mask    = '0;
        wr_data    = '0;
        rd_addr    = '0;
        s_clr_req  = 1'b0;
        s_wr_valid = 1'b0;
        s_wr_addr  = '0;
        s_wr_mask  = '0;
        s_wr_data  = '0;
        s_rd_addr  = '0;

        test_reset();
        test_masked_write();
        test_bypass();
        test_random_traffic();
        test_clr_vs_write();
        test_clr_ignored_and_reset();
        test_small_config();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
